// File: rtl/display_pkg.sv
// Shared display types and pipeline constants for the sprite compositor.
package display_pkg;

  typedef logic [11:0] rgb12;

  localparam rgb12 TRANSPARENT  = 12'h000;
  localparam int   PIPE_LATENCY = 3;
  localparam int   HC_W         = 11;
  localparam int   VC_W         = 10;
  localparam int   REL_W        = 5;

  function automatic logic opaque(input rgb12 pix);
    return pix != TRANSPARENT;
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// Combinational hit test and sprite-relative coordinates for one sprite layer.
module sprite_hit
  import display_pkg::*;
#(
  parameter int SPR_W = 20,
  parameter int SPR_H = 20
) (
  input  logic [HC_W-1:0]  hcount,
  input  logic [VC_W-1:0]  vcount,
  input  logic [HC_W-1:0]  x,
  input  logic [VC_W-1:0]  y,
  input  logic             en,
  output logic             hit,
  output logic [REL_W-1:0] rel_x,
  output logic [REL_W-1:0] rel_y
);

  logic [HC_W:0] x_end;
  logic [VC_W:0] y_end;

  // One extra bit keeps sprites near the right/bottom edge from wrapping to column/row 0.
  assign x_end = {1'b0, x} + (HC_W+1)'(SPR_W);
  assign y_end = {1'b0, y} + (VC_W+1)'(SPR_H);

  assign hit = en && (hcount >= x) && ({1'b0, hcount} < x_end)
                  && (vcount >= y) && ({1'b0, vcount} < y_end);

  assign rel_x = REL_W'(hcount - x);
  assign rel_y = REL_W'(vcount - y);

endmodule

// File: rtl/layer_compositor.sv
// Three-stage sprite-over-wave compositor with vsync-latched sprite state.
// Optional frame animation counter enabled by defining COMPOSITOR_ANIM_EN.
module layer_compositor
  import display_pkg::*;
#(
  parameter int   NUM_SPRITES = 4,
  parameter int   SPR_W       = 20,
  parameter int   SPR_H       = 20,
  parameter int   LOG_FRAMES  = 2,
  parameter rgb12 UPPER_COLOR = 12'hFFF,
  parameter rgb12 LOWER_COLOR = 12'h00F,
  parameter int   ANIM_DIV    = 8
) (
  input  logic                             vclock,
  input  logic                             reset,
  input  logic [HC_W-1:0]                  hcount,
  input  logic [VC_W-1:0]                  vcount,
  input  logic                             hsync,
  input  logic                             vsync,
  input  logic                             blank,
  input  logic [VC_W-1:0]                  wave_prof,
  input  logic [NUM_SPRITES*HC_W-1:0]      spr_x,
  input  logic [NUM_SPRITES*VC_W-1:0]      spr_y,
  input  logic [NUM_SPRITES*LOG_FRAMES-1:0] spr_frame,
  input  logic [NUM_SPRITES-1:0]           spr_en,
  output logic [NUM_SPRITES*REL_W-1:0]     rom_x,
  output logic [NUM_SPRITES*REL_W-1:0]     rom_y,
  output logic [NUM_SPRITES*LOG_FRAMES-1:0] rom_frame,
  input  logic [NUM_SPRITES*12-1:0]        rom_pix,
  output rgb12                             p_rgb,
  output logic                             hsync_out,
  output logic                             vsync_out,
  output logic                             blank_out
);

  localparam int NS = NUM_SPRITES;
  localparam int LF = LOG_FRAMES;

  logic                vsync_reg;
  logic                vsync_fall;
  logic [NS*HC_W-1:0]  shadow_x_reg;
  logic [NS*VC_W-1:0]  shadow_y_reg;
  logic [NS*LF-1:0]    shadow_frame_reg;
  logic [NS-1:0]       shadow_en_reg;

  logic [NS-1:0]       hit_next;
  logic [NS*REL_W-1:0] rel_x_next;
  logic [NS*REL_W-1:0] rel_y_next;
  logic [NS*LF-1:0]    frame_next;
  rgb12                bg_next;
  rgb12                pix_next;

  logic [NS-1:0]       s1_hit_reg;
  logic [NS-1:0]       s2_hit_reg;
  rgb12                s1_bg_reg;
  rgb12                s2_bg_reg;
  // {blank, vsync, hsync} delay line; entry k is the stage-(k+1) copy.
  logic [2:0]          ctl_pipe_reg [PIPE_LATENCY];

  assign vsync_fall = vsync_reg & ~vsync;

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      vsync_reg        <= 1'b0;
      shadow_x_reg     <= '0;
      shadow_y_reg     <= '0;
      shadow_frame_reg <= '0;
      shadow_en_reg    <= '0;
    end else begin
      vsync_reg <= vsync;
      if (vsync_fall) begin
        shadow_x_reg     <= spr_x;
        shadow_y_reg     <= spr_y;
        shadow_frame_reg <= spr_frame;
        shadow_en_reg    <= spr_en;
      end
    end
  end

`ifdef COMPOSITOR_ANIM_EN
  localparam int DIV_W = $clog2(ANIM_DIV + 1);

  logic [DIV_W-1:0] div_reg;
  logic [LF-1:0]    anim_reg;

  // div_reg counts latch events 1..ANIM_DIV, so the first ANIM_DIV frames use step 0.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      div_reg  <= '0;
      anim_reg <= '0;
    end else if (vsync_fall) begin
      if (div_reg == DIV_W'(ANIM_DIV)) begin
        div_reg  <= DIV_W'(1);
        anim_reg <= anim_reg + 1'b1;
      end else begin
        div_reg <= div_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NS; gi++) begin : g_anim
    assign frame_next[gi*LF +: LF] = shadow_frame_reg[gi*LF +: LF] + anim_reg;
  end
`else
  assign frame_next = shadow_frame_reg;
`endif

  for (genvar gi = 0; gi < NS; gi++) begin : g_sprite
    sprite_hit #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
    ) u_hit (
      .hcount (hcount),
      .vcount (vcount),
      .x      (shadow_x_reg[gi*HC_W +: HC_W]),
      .y      (shadow_y_reg[gi*VC_W +: VC_W]),
      .en     (shadow_en_reg[gi]),
      .hit    (hit_next[gi]),
      .rel_x  (rel_x_next[gi*REL_W +: REL_W]),
      .rel_y  (rel_y_next[gi*REL_W +: REL_W])
    );
  end

  assign bg_next = (vcount > wave_prof) ? LOWER_COLOR : UPPER_COLOR;

  // Highest index first so the lowest opaque sprite overwrites last and wins.
  always_comb begin
    pix_next = s2_bg_reg;
    for (int i = NS - 1; i >= 0; i--) begin
      if (s2_hit_reg[i] && opaque(rom_pix[i*12 +: 12]))
        pix_next = rom_pix[i*12 +: 12];
    end
    if (ctl_pipe_reg[1][2])
      pix_next = 12'h000;
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      s1_hit_reg <= '0;
      s2_hit_reg <= '0;
      s1_bg_reg  <= '0;
      s2_bg_reg  <= '0;
      rom_x      <= '0;
      rom_y      <= '0;
      rom_frame  <= '0;
      p_rgb      <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++)
        ctl_pipe_reg[i] <= 3'b111;
    end else begin
      s1_hit_reg      <= hit_next;
      s1_bg_reg       <= bg_next;
      rom_x           <= rel_x_next;
      rom_y           <= rel_y_next;
      rom_frame       <= frame_next;
      s2_hit_reg      <= s1_hit_reg;
      s2_bg_reg       <= s1_bg_reg;
      ctl_pipe_reg[0] <= {blank, vsync, hsync};
      for (int i = 1; i < PIPE_LATENCY; i++)
        ctl_pipe_reg[i] <= ctl_pipe_reg[i-1];
      p_rgb           <= pix_next;
    end
  end

  assign {blank_out, vsync_out, hsync_out} = ctl_pipe_reg[PIPE_LATENCY-1];

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: expected pixels queued at drive time, popped at output.
module tb_layer_compositor;
  import display_pkg::*;

  localparam int NS    = 4;
  localparam int SPR_W = 20;
  localparam int SPR_H = 20;
  localparam int LF    = 2;

  logic              vclock;
  logic              reset;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic              hsync, vsync, blank;
  logic [9:0]        wave_prof;
  logic [NS*11-1:0]  spr_x;
  logic [NS*10-1:0]  spr_y;
  logic [NS*LF-1:0]  spr_frame;
  logic [NS-1:0]     spr_en;
  logic [NS*5-1:0]   rom_x, rom_y;
  logic [NS*LF-1:0]  rom_frame;
  logic [NS*12-1:0]  rom_pix;
  rgb12              p_rgb;
  logic              hsync_out, vsync_out, blank_out;

  layer_compositor #(
    .NUM_SPRITES (NS),
    .SPR_W       (SPR_W),
    .SPR_H       (SPR_H),
    .LOG_FRAMES  (LF),
    .UPPER_COLOR (12'hFFF),
    .LOWER_COLOR (12'h00F),
    .ANIM_DIV    (8)
  ) dut (
    .vclock    (vclock),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .hsync     (hsync),
    .vsync     (vsync),
    .blank     (blank),
    .wave_prof (wave_prof),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .spr_frame (spr_frame),
    .spr_en    (spr_en),
    .rom_x     (rom_x),
    .rom_y     (rom_y),
    .rom_frame (rom_frame),
    .rom_pix   (rom_pix),
    .p_rgb     (p_rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .blank_out (blank_out)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

  // ROM stand-in: one solid colour per sprite, one cycle of read latency.
  rgb12 rom_color [NS];
  always @(posedge vclock)
    for (int i = 0; i < NS; i++)
      rom_pix[i*12 +: 12] <= rom_color[i];

  // Model of the shadow registers, refreshed whenever the bench issues a vsync fall.
  int          m_x [NS];
  int          m_y [NS];
  logic [LF-1:0] m_frame [NS];
  logic        m_en [NS];

  typedef struct {
    rgb12 rgb;
    logic bl;
    logic hs;
    logic vs;
  } exp_t;
  exp_t exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic rgb12 model_pix(input int h, input int v, input int wp, input logic bl);
    if (bl) return 12'h000;
    for (int i = 0; i < NS; i++)
      if (m_en[i] && h >= m_x[i] && h < m_x[i] + SPR_W && v >= m_y[i] && v < m_y[i] + SPR_H
          && rom_color[i] != 12'h000)
        return rom_color[i];
    return (v > wp) ? 12'h00F : 12'hFFF;
  endfunction

  task automatic drive(input int h, input int v, input int wp, input logic bl, input logic hs);
    exp_t e;
    hcount    = 11'(h);
    vcount    = 10'(v);
    wave_prof = 10'(wp);
    blank     = bl;
    hsync     = hs;
    vsync     = 1'b1;
    e.rgb = model_pix(h, v, wp, bl);
    e.bl  = bl;
    e.hs  = hs;
    e.vs  = 1'b1;
    exp_q.push_back(e);
    @(posedge vclock); #1;
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input int fr, input logic en);
    spr_x[i*11 +: 11]     = 11'(x);
    spr_y[i*10 +: 10]     = 10'(y);
    spr_frame[i*LF +: LF] = LF'(fr);
    spr_en[i]             = en;
  endtask

  task automatic frame_sync();
    blank = 1'b1;
    hsync = 1'b1;
    vsync = 1'b0;
    repeat (2) begin @(posedge vclock); #1; end
    vsync = 1'b1;
    repeat (PIPE_LATENCY + 1) begin @(posedge vclock); #1; end
    exp_q.delete();
    for (int i = 0; i < NS; i++) begin
      m_x[i]     = int'(spr_x[i*11 +: 11]);
      m_y[i]     = int'(spr_y[i*10 +: 10]);
      m_frame[i] = spr_frame[i*LF +: LF];
      m_en[i]    = spr_en[i];
    end
  endtask

  task automatic test_reset();
    if (p_rgb !== 12'h000) begin n_fail++; $display("FAIL reset_p_rgb: got %h want 000", p_rgb); end
    if (rom_x !== '0) begin n_fail++; $display("FAIL reset_rom_x: got %h want 0", rom_x); end
    if (rom_frame !== '0) begin n_fail++; $display("FAIL reset_rom_frame: got %h want 0", rom_frame); end
    if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_hsync_out: got %b want 1", hsync_out); end
    if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_vsync_out: got %b want 1", vsync_out); end
    if (blank_out !== 1'b1) begin n_fail++; $display("FAIL reset_blank_out: got %b want 1", blank_out); end
    n_tests += 6;
    $display("[TB] reset state checked");
  endtask

  task automatic test_background();
    exp_t e;
    spr_en = '0;
    frame_sync();
    // Per-column profile: rows below the profile switch to the lower colour.
    for (int h = 0; h < 12; h++) begin
      drive(h, 5, h, 1'b0, 1'b1);
      if (exp_q.size() == PIPE_LATENCY) begin
        e = exp_q.pop_front();
        n_tests++;
        if (p_rgb !== e.rgb) begin n_fail++; $display("FAIL background_profile: got %h want %h", p_rgb, e.rgb); end
      end
    end
    for (int v = 299; v <= 301; v++)
      for (int h = 0; h < 4; h++) begin
        drive(h, v, 300, 1'b0, 1'b1);
        if (exp_q.size() == PIPE_LATENCY) begin
          e = exp_q.pop_front();
          n_tests++;
          if (p_rgb !== e.rgb) begin n_fail++; $display("FAIL background_row: v=%0d got %h want %h", v, p_rgb, e.rgb); end
        end
      end
    $display("[TB] background scan done");
  endtask

  task automatic test_single_sprite();
    exp_t e;
    int rows [4] = '{199, 200, 219, 220};
    set_sprite(0, 100, 200, 0, 1'b1);
    rom_color[0] = 12'h0F0;
    frame_sync();
    for (int r = 0; r < 4; r++)
      for (int h = 98; h <= 121; h++) begin
        drive(h, rows[r], 0, 1'b0, 1'b1);
        if (exp_q.size() == PIPE_LATENCY) begin
          e = exp_q.pop_front();
          n_tests++;
          if (p_rgb !== e.rgb) begin n_fail++; $display("FAIL single_sprite: row=%0d got %h want %h", rows[r], p_rgb, e.rgb); end
        end
      end
    $display("[TB] single sprite window done");
  endtask

  task automatic test_rom_coords();
    logic [NS*LF-1:0] exp_f;
    exp_q.delete();
    drive(107, 213, 0, 1'b0, 1'b1);
    for (int i = 0; i < NS; i++) exp_f[i*LF +: LF] = m_frame[i];
    n_tests += 3;
    if (rom_x[4:0] !== 5'd7) begin n_fail++; $display("FAIL rom_x: got %0d want 7", rom_x[4:0]); end
    if (rom_y[4:0] !== 5'd13) begin n_fail++; $display("FAIL rom_y: got %0d want 13", rom_y[4:0]); end
`ifndef COMPOSITOR_ANIM_EN
    if (rom_frame !== exp_f) begin n_fail++; $display("FAIL rom_frame: got %h want %h", rom_frame, exp_f); end
`else
    if (rom_frame[LF-1:0] === 'x) begin n_fail++; $display("FAIL rom_frame: got %h want known", rom_frame); end
`endif
    exp_q.delete();
    $display("[TB] rom coordinates checked");
  endtask

  task automatic test_priority();
    exp_t e;
    set_sprite(0, 300, 300, 0, 1'b1);
    set_sprite(1, 300, 300, 1, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      rom_color[0] = (pass == 0) ? 12'h000 : 12'h0F0;
      rom_color[1] = 12'hF0F;
      frame_sync();
      for (int h = 298; h <= 321; h++) begin
        drive(h, 310, 0, 1'b0, 1'b1);
        if (exp_q.size() == PIPE_LATENCY) begin
          e = exp_q.pop_front();
          n_tests++;
          if (p_rgb !== e.rgb) begin n_fail++; $display("FAIL priority: pass=%0d got %h want %h", pass, p_rgb, e.rgb); end
        end
      end
    end
    $display("[TB] priority and fall-through done");
  endtask

  task automatic test_shadow();
    exp_t e;
    set_sprite(1, 0, 0, 0, 1'b0);
    set_sprite(0, 100, 200, 0, 1'b1);
    rom_color[0] = 12'h0F0;
    frame_sync();
    for (int step = 0; step < 3; step++) begin
      if (step == 1) set_sprite(0, 400, 200, 0, 1'b1);
      if (step == 2) frame_sync();
      for (int h = 98; h <= 121; h++) begin
        drive(h, 210 + step, 0, 1'b0, 1'b1);
        if (exp_q.size() == PIPE_LATENCY) begin
          e = exp_q.pop_front();
          n_tests++;
          if (p_rgb !== e.rgb) begin n_fail++; $display("FAIL shadow_x100: step=%0d got %h want %h", step, p_rgb, e.rgb); end
        end
      end
      for (int h = 398; h <= 421; h++) begin
        drive(h, 210 + step, 0, 1'b0, 1'b1);
        if (exp_q.size() == PIPE_LATENCY) begin
          e = exp_q.pop_front();
          n_tests++;
          if (p_rgb !== e.rgb) begin n_fail++; $display("FAIL shadow_x400: step=%0d got %h want %h", step, p_rgb, e.rgb); end
        end
      end
    end
    $display("[TB] shadow latch timing done");
  endtask

  task automatic test_blank();
    exp_t e;
    set_sprite(0, 100, 200, 0, 1'b1);
    frame_sync();
    for (int h = 95; h <= 125; h++) begin
      drive(h, 205, 0, (h >= 108 && h <= 111), !(h >= 120 && h <= 122));
      if (exp_q.size() == PIPE_LATENCY) begin
        e = exp_q.pop_front();
        n_tests++;
        if (p_rgb !== e.rgb || blank_out !== e.bl || hsync_out !== e.hs || vsync_out !== e.vs) begin
          n_fail++;
          $display("FAIL blank_align: got rgb=%h bl=%b hs=%b vs=%b want rgb=%h bl=%b hs=%b vs=%b",
                   p_rgb, blank_out, hsync_out, vsync_out, e.rgb, e.bl, e.hs, e.vs);
        end
      end
    end
    $display("[TB] blank and sync alignment done");
  endtask

  task automatic test_clip();
    exp_t e;
    int rows [3] = '{1014, 1020, 1023};
    set_sprite(0, 2040, 1015, 0, 1'b1);
    frame_sync();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 18; k++) begin
        drive((2036 + k) % 2048, rows[r], 0, 1'b0, 1'b1);
        if (exp_q.size() == PIPE_LATENCY) begin
          e = exp_q.pop_front();
          n_tests++;
          if (p_rgb !== e.rgb) begin n_fail++; $display("FAIL clip: row=%0d got %h want %h", rows[r], p_rgb, e.rgb); end
        end
      end
    $display("[TB] edge clipping done");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    set_sprite(0, 100, 200, 0, 1'b1);
    frame_sync();
    for (int h = 100; h <= 110; h++) drive(h, 205, 0, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    n_tests += 4;
    if (p_rgb !== 12'h000) begin n_fail++; $display("FAIL async_reset_p_rgb: got %h want 000", p_rgb); end
    if (blank_out !== 1'b1) begin n_fail++; $display("FAIL async_reset_blank_out: got %b want 1", blank_out); end
    if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL async_reset_vsync_out: got %b want 1", vsync_out); end
    if (rom_x !== '0) begin n_fail++; $display("FAIL async_reset_rom_x: got %h want 0", rom_x); end
    @(posedge vclock); #2 reset = 1'b0;
    for (int i = 0; i < NS; i++) m_en[i] = 1'b0;
    exp_q.delete();
    @(posedge vclock); #1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) frame_sync();
      for (int h = 98; h <= 112; h++) begin
        drive(h, 205, 0, 1'b0, 1'b1);
        if (exp_q.size() == PIPE_LATENCY) begin
          e = exp_q.pop_front();
          n_tests++;
          if (p_rgb !== e.rgb) begin n_fail++; $display("FAIL post_reset: pass=%0d got %h want %h", pass, p_rgb, e.rgb); end
        end
      end
    end
    $display("[TB] mid-frame reset done");
  endtask

`ifdef COMPOSITOR_ANIM_EN
  task automatic test_anim();
    logic [LF-1:0] want;
    @(posedge vclock); #2 reset = 1'b1;
    #4 reset = 1'b0;
    @(posedge vclock); #1;
    set_sprite(0, 100, 200, 3, 1'b1);
    for (int k = 0; k < 24; k++) begin
      frame_sync();
      drive(0, 0, 0, 1'b1, 1'b1);
      want = LF'(m_frame[0] + LF'(k / 8));
      n_tests++;
      if (rom_frame[LF-1:0] !== want) begin n_fail++; $display("FAIL anim_frame: frame=%0d got %0d want %0d", k, rom_frame[LF-1:0], want); end
    end
    exp_q.delete();
    $display("[TB] animation counter done");
  endtask
`endif

  initial begin
    reset     = 1'b1;
    hcount    = '0;
    vcount    = '0;
    wave_prof = '0;
    hsync     = 1'b1;
    vsync     = 1'b1;
    blank     = 1'b1;
    spr_x     = '0;
    spr_y     = '0;
    spr_frame = '0;
    spr_en    = '0;
    for (int i = 0; i < NS; i++) begin
      rom_color[i] = 12'h000;
      m_x[i] = 0; m_y[i] = 0; m_frame[i] = '0; m_en[i] = 1'b0;
    end
    #23;
    test_reset();
    @(posedge vclock); #2 reset = 1'b0;
    @(posedge vclock); #1;

    test_background();
    test_single_sprite();
    test_rom_coords();
    test_priority();
    test_shadow();
    test_blank();
    test_clip();
    test_reset_mid();
`ifdef COMPOSITOR_ANIM_EN
    test_anim();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
